wb_timer: RTL and testbench

Memory-mapped timer peripheral acting as a Wishbone classic responder on the CPU data/instruction bus. Holds a prescaled 32-bit up-counter, a compare register and a sticky match flag that drives a level interrupt. It decodes its own 8-word window, so an external address decoder gates `cyc_i`/`stb_i` for it.

---
 rtl/wb_timer_if.sv | 24 ++
 rtl/wb_timer.sv | 146 ++++++++++++++
 tb/tb_wb_timer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle for the wb_timer peripheral, including its level interrupt.
interface wb_timer_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic        irq_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o, rty_o, irq_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o, rty_o, irq_o
    );
endinterface

// File: rtl/wb_timer.sv
// Wishbone classic timer: prescaled 32-bit up-counter, compare register, sticky match flag
// and level interrupt in an 8-word register window.
module wb_timer #(
    parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
    input logic       clk_i,
    input logic       rst_i,
    wb_timer_if.slave bus
);
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_COMPARE  = 3'd3;

    logic        enable_q, enable_d, reload_q, reload_d;
    logic        irq_en_q, irq_en_d, flag_q, flag_d;
    logic [15:0] prescale_q, prescale_d, pre_q, pre_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d, err_q, err_d;

    logic        req, mapped, wr, tick, match;
    logic [2:0]  idx;
    logic [31:0] rdata, count_wr, compare_wr;
    logic [15:0] prescale_wr;
    logic        unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                          input logic [3:0] sel);
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[8*n +: 8] = sel[n] ? wdat[8*n +: 8] : old[8*n +: 8];
        end
        return res;
    endfunction

    assign unused_adr  = ^{bus.adr_i[31:5], bus.adr_i[1:0]};
    assign idx         = bus.adr_i[4:2];
    assign mapped      = ~idx[2];
    // A pending ack/err masks the next edge so a held strobe is not accepted twice.
    assign req         = bus.cyc_i & bus.stb_i & ~ack_q & ~err_q;
    assign wr          = req & bus.we_i & mapped;
    assign tick        = enable_q && (pre_q == prescale_q);
    assign match       = tick && (count_q == compare_q);
    assign count_wr    = merge(count_q, bus.dat_i, bus.sel_i);
    assign compare_wr  = merge(compare_q, bus.dat_i, bus.sel_i);
    assign prescale_wr = {bus.sel_i[1] ? bus.dat_i[15:8] : prescale_q[15:8],
                          bus.sel_i[0] ? bus.dat_i[7:0]  : prescale_q[7:0]};

    always_comb begin
        rdata = '0;
        case (idx)
            ADDR_CTRL:     rdata = {23'd0, flag_q, 5'd0, irq_en_q, reload_q, enable_q};
            ADDR_PRESCALE: rdata = {16'd0, prescale_q};
            ADDR_COUNT:    rdata = count_q;
            ADDR_COMPARE:  rdata = compare_q;
            default:       rdata = '0;
        endcase
    end

    always_comb begin
        enable_d   = enable_q;
        reload_d   = reload_q;
        irq_en_d   = irq_en_q;
        flag_d     = flag_q;
        prescale_d = prescale_q;
        pre_d      = pre_q;
        count_d    = count_q;
        compare_d  = compare_q;

        if (enable_q) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end
        if (tick) begin
            count_d = (match && reload_q) ? 32'd0 : count_q + 32'd1;
        end

        if (wr) begin
            case (idx)
                ADDR_CTRL: begin
                    if (bus.sel_i[0]) begin
                        enable_d = bus.dat_i[0];
                        reload_d = bus.dat_i[1];
                        irq_en_d = bus.dat_i[2];
                    end
                    if (bus.sel_i[1] && bus.dat_i[8]) begin
                        flag_d = 1'b0;
                    end
                end
                ADDR_PRESCALE: begin
                    prescale_d = prescale_wr;
                    pre_d      = 16'd0;
                end
                ADDR_COUNT: begin
                    count_d = count_wr;
                    pre_d   = 16'd0;
                end
                ADDR_COMPARE: compare_d = compare_wr;
                default: ;
            endcase
        end

        // A match wins over a same-edge W1C so no event is lost.
        if (match) begin
            flag_d = 1'b1;
        end

        ack_d = req & mapped;
        err_d = req & ~mapped;
        dat_d = (req & mapped) ? rdata : 32'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q   <= 1'b0;
            reload_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            flag_q     <= 1'b0;
            prescale_q <= RESET_PRESCALE;
            pre_q      <= 16'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            dat_q      <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            reload_q   <= reload_d;
            irq_en_q   <= irq_en_d;
            flag_q     <= flag_d;
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.dat_o = dat_q;
    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.rty_o = 1'b0;
    assign bus.irq_o = flag_q & irq_en_q;
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios plus randomized runs scored against
// a closed-form model of the counter/compare behaviour.
module tb_wb_timer;
    localparam logic [15:0] RST_PRE = 16'h0003;
    localparam logic [31:0] A_CTRL  = 32'h0;
    localparam logic [31:0] A_PRE   = 32'h4;
    localparam logic [31:0] A_COUNT = 32'h8;
    localparam logic [31:0] A_CMP   = 32'hC;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] r_dat;
    logic        r_ack, r_err, r_irq, r_ack_n, r_err_n;

    wb_timer_if bus();

    wb_timer #(.RESET_PRESCALE(RST_PRE)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One transfer: accepted at the first rising edge, results sampled 1ns later,
    // then the follow-up cycle is sampled to confirm the pulse ended.
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] wdat);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = adr;  bus.sel_i = sel;  bus.dat_i = wdat;
        @(posedge clk);
        #1;
        r_dat = bus.dat_o; r_ack = bus.ack_o; r_err = bus.err_o; r_irq = bus.irq_o;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        @(posedge clk);
        #1;
        r_ack_n = bus.ack_o; r_err_n = bus.err_o;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
        bus_xfer(1'b1, adr, 4'hF, wdat);
    endtask

    task automatic rd(input logic [31:0] adr);
        bus_xfer(1'b0, adr, 4'hF, 32'd0);
    endtask

    // Counter state after t ticks, starting at c with compare k.
    task automatic model(input longint c, input longint k, input bit r, input longint t,
                         output longint cnt, output bit flg);
        longint d;
        d = (k - c) & 64'hFFFF_FFFF;
        if (t <= d) begin
            cnt = (c + t) & 64'hFFFF_FFFF;
            flg = 1'b0;
        end else begin
            flg = 1'b1;
            if (!r) cnt = (c + t) & 64'hFFFF_FFFF;
            else    cnt = (t - d - 1) % (k + 1);
        end
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        wr(A_COUNT, 32'h55);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = A_COUNT; bus.sel_i = 4'hF;
        @(posedge clk);
        #2;
        checks++;
        if (bus.ack_o !== 1'b1 || bus.dat_o !== 32'h55) begin
            errors++;
            $display("FAIL pre_reset_ack: got ack=%b dat=%h want ack=1 dat=00000055",
                     bus.ack_o, bus.dat_o);
        end
        rst_i = 1'b1;
        #1;
        outs = {bus.ack_o, bus.err_o, bus.irq_o, bus.dat_o};
        checks++;
        if (outs !== 35'd0 || bus.rty_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h rty=%b want 0", outs, bus.rty_o);
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %h want 0", r_dat);
        end
        rd(A_PRE);
        checks++;
        if (r_dat !== {16'd0, RST_PRE}) begin
            errors++; $display("FAIL reset_prescale: got %h want %h", r_dat, {16'd0, RST_PRE});
        end
        rd(A_CMP);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++; $display("FAIL reset_compare: got %h want 0", r_dat);
        end
        rd(A_CTRL);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h want 0", r_dat);
        end
        // Reset across the accepting edge drops the write.
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.adr_i = A_COUNT; bus.sel_i = 4'hF; bus.dat_i = 32'h1234;
        #2 rst_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ack_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_req_ack: got %b want 0", bus.ack_o);
        end
        @(negedge clk);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        rst_i = 1'b0;
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++; $display("FAIL reset_mid_req_write: got %h want 0", r_dat);
        end
    endtask

    task automatic test_compare_reload();
        wr(A_PRE, 32'd0);
        wr(A_CMP, 32'd5);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'd1) begin
            errors++; $display("FAIL cmp_count_early: got %h want 1", r_dat);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.irq_o !== 1'b0) begin
            errors++; $display("FAIL cmp_irq_before_match: got %b want 0", bus.irq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.irq_o !== 1'b1) begin
            errors++; $display("FAIL cmp_irq_after_match: got %b want 1", bus.irq_o);
        end
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++; $display("FAIL cmp_reload: got %h want 0", r_dat);
        end
        rd(A_CTRL);
        checks++;
        if (r_dat !== 32'h107 || r_irq !== 1'b1) begin
            errors++; $display("FAIL cmp_ctrl_flag: got %h irq=%b want 107 irq=1", r_dat, r_irq);
        end
        wr(A_CTRL, 32'h107);
        checks++;
        if (r_irq !== 1'b0) begin
            errors++; $display("FAIL cmp_w1c_irq: got %b want 0", r_irq);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_prescaler();
        wr(A_CTRL, 32'h100);
        wr(A_PRE, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        for (int j = 0; j < 6; j++) begin
            rd(A_COUNT);
            checks++;
            if (r_dat !== 32'((1 + 2 * j) / 4)) begin
                errors++;
                $display("FAIL presc_count_%0d: got %h want %h", j, r_dat, (1 + 2 * j) / 4);
            end
        end
        wr(A_COUNT, 32'h10);
        for (int k = 0; k < 3; k++) begin
            rd(A_COUNT);
            checks++;
            if (r_dat !== 32'h10 + 32'((1 + 2 * k) / 4)) begin
                errors++;
                $display("FAIL presc_phase_%0d: got %h want %h", k, r_dat,
                         32'h10 + 32'((1 + 2 * k) / 4));
            end
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_byte_lanes();
        wr(A_COUNT, 32'h1122_3344);
        bus_xfer(1'b1, A_COUNT, 4'b0100, 32'hAABB_CCDD);
        checks++;
        if (r_ack !== 1'b1 || r_ack_n !== 1'b0) begin
            errors++; $display("FAIL lane_write_ack: got %b,%b want 1,0", r_ack, r_ack_n);
        end
        bus_xfer(1'b0, A_COUNT, 4'b0001, 32'd0);
        checks++;
        if (r_dat !== 32'h11BB_3344) begin
            errors++; $display("FAIL lane_merge: got %h want 11bb3344", r_dat);
        end
    endtask

    task automatic test_error_handshake();
        int acks;
        rd(32'h14);
        checks++;
        if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 32'd0 || r_err_n !== 1'b0) begin
            errors++;
            $display("FAIL err_read: got err=%b ack=%b dat=%h err_next=%b want 1 0 0 0",
                     r_err, r_ack, r_dat, r_err_n);
        end
        wr(32'h18, 32'hDEAD);
        checks++;
        if (r_err !== 1'b1 || r_ack !== 1'b0) begin
            errors++; $display("FAIL err_write: got err=%b ack=%b want 1 0", r_err, r_ack);
        end
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'h11BB_3344) begin
            errors++; $display("FAIL err_no_side_effect: got %h want 11bb3344", r_dat);
        end
        acks = 0;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = A_COUNT; bus.sel_i = 4'hF;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.ack_o === 1'b1) acks++;
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        checks++;
        if (acks !== 2) begin
            errors++; $display("FAIL held_stb_acks: got %0d want 2", acks);
        end
    endtask

    task automatic test_races();
        wr(A_CTRL, 32'h100);
        wr(A_PRE, 32'd1);
        wr(A_CMP, 32'hFFFF_FFFF);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        wr(A_CTRL, 32'h101);  // lands on the matching tick
        wr(A_CTRL, 32'h0);
        rd(A_COUNT);
        checks++;
        if (r_dat !== 32'd1) begin
            errors++; $display("FAIL race_wrap_count: got %h want 1", r_dat);
        end
        rd(A_CTRL);
        checks++;
        if (r_dat !== 32'h100) begin
            errors++; $display("FAIL race_flag_kept: got %h want 100", r_dat);
        end
    endtask

    task automatic test_random();
        logic [31:0] k, c;
        int          p, w, mode;
        bit          r, ie, flg;
        longint      cnt, t;
        for (int it = 0; it < 24; it++) begin
            p    = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            r    = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            w    = $urandom_range(0, 40);
            if (mode == 0) begin
                k = $urandom; c = k - 32'($urandom_range(0, 12));
            end else if (mode == 1) begin
                k = 32'($urandom_range(0, 6)); c = 32'($urandom_range(0, k));
            end else begin
                k = 32'hFFFF_FFFF; c = k - 32'($urandom_range(0, 5));
            end
            wr(A_CTRL, 32'h0);
            wr(A_PRE, 32'(p));
            wr(A_COUNT, c);
            wr(A_CMP, k);
            wr(A_CTRL, 32'h100);
            wr(A_CTRL, {29'd0, ie, r, 1'b1});
            repeat (w) @(posedge clk);
            #1;
            t = longint'((w + 1) / (p + 1));
            model(longint'(c), longint'(k), r, t, cnt, flg);
            checks++;
            if (bus.irq_o !== (ie & flg)) begin
                errors++;
                $display("FAIL rand_irq_%0d: got %b want %b", it, bus.irq_o, ie & flg);
            end
            wr(A_CTRL, 32'h0);
            t = longint'((w + 2) / (p + 1));
            model(longint'(c), longint'(k), r, t, cnt, flg);
            rd(A_COUNT);
            checks++;
            if (r_dat !== 32'(cnt)) begin
                errors++;
                $display("FAIL rand_count_%0d: got %h want %h (c=%h k=%h p=%0d w=%0d r=%b)",
                         it, r_dat, 32'(cnt), c, k, p, w, r);
            end
            rd(A_CTRL);
            checks++;
            if (r_dat !== {23'd0, flg, 8'd0}) begin
                errors++;
                $display("FAIL rand_flag_%0d: got %h want %h", it, r_dat, {23'd0, flg, 8'd0});
            end
        end
    endtask

    initial begin
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.adr_i = 32'd0; bus.sel_i = 4'd0; bus.dat_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        test_reset();
        test_compare_reload();
        test_prescaler();
        test_byte_lanes();
        test_error_handshake();
        test_races();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
